// File: rtl/csr_pkg.sv
// csr_pkg: shared FSM encoding, register offsets and field positions for the CSR front-end
package csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    localparam int CTRL_ADDR   = 0;
    localparam int DATA_BASE   = 1;
    localparam int CTRL_OP_LSB = 0;
    localparam int IRQ_RES_BIT = 0;
    localparam int IRQ_ERR_BIT = 1;
    localparam int IRQ_CLR_BIT = 2;

    function automatic int res_addr(input int n);
        return n + 1;
    endfunction

    function automatic int status_addr(input int n);
        return n + 2;
    endfunction

    function automatic int irq_mask_addr(input int n);
        return n + 3;
    endfunction

    function automatic int ctrl_start_bit(input int op_size);
        return op_size;
    endfunction

endpackage

// File: rtl/csr_wait_counter.sv
// csr_wait_counter: loadable down-counter whose done flag ends the read wait phase
module csr_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    assign done = (count == '0);

    // load on every setup cycle, then count down to zero and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !done)
            count <= count - WIDTH'(1);
    end

endmodule

// File: rtl/csr_control_multi.sv
// csr_control_multi: APB slave front-end for the ALU control/status register file
module csr_control_multi
    import csr_pkg::*;
#(
    parameter int NUM_OPERANDS = 2,
    parameter int OPERATION_SIZE = 2,
    parameter logic [2**OPERATION_SIZE-1:0] OP_VALID_MASK = 4'b0110,
    parameter int FIFO_OUT_WIDTH = 25,
    parameter int APB_BUS_SIZE = 32,
    parameter int READ_WAIT = 1,
    parameter int ADDR_WIDTH = $clog2(NUM_OPERANDS + 4)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      sel,
    input  logic                      en,
    input  logic                      write,
    input  logic [APB_BUS_SIZE-1:0]   wdata,
    input  logic [FIFO_OUT_WIDTH-1:0] final_result,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
    input  logic                      full_in,
    input  logic                      empty_out,
    output logic                      ready,
    output logic                      slv_err,
    output logic [APB_BUS_SIZE-1:0]   rdata,
    output logic                      en_ctrl,
    output logic [NUM_OPERANDS-1:0]   en_data,
    output logic                      r_en_out,
    output logic                      w_en_in,
    output logic                      irq
);

    localparam int RES_A     = res_addr(NUM_OPERANDS);
    localparam int STATUS_A  = status_addr(NUM_OPERANDS);
    localparam int MASK_A    = irq_mask_addr(NUM_OPERANDS);
    localparam int START_BIT = ctrl_start_bit(OPERATION_SIZE);
    localparam int CW        = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    state_t                    state, next_state;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      write_q, err_q, start_q;
    logic [1:0]                irq_mask;
    logic                      err_sticky;
    logic                      wait_done;
    logic [31:0]               a_in, a_q;
    logic [OPERATION_SIZE-1:0] op;
    logic                      in_opreg, in_res, in_status;
    logic                      setup_err, res_ok, access, ok, mask_wr;
    logic                      unused_wdata;

    assign a_in         = 32'(addr);
    assign a_q          = 32'(addr_q);
    assign op           = wdata[CTRL_OP_LSB +: OPERATION_SIZE];
    assign unused_wdata = ^wdata;

    // address decode of the live bus, valid while in SETUP
    assign in_opreg  = a_in < 32'(RES_A);
    assign in_res    = a_in == 32'(RES_A);
    assign in_status = a_in == 32'(STATUS_A);
    assign res_ok    = !write && in_res && !empty_out;
    assign setup_err = (a_in > 32'(MASK_A))
                     | (!write && in_opreg)
                     | (write && (in_res || in_status))
                     | (write && in_opreg && full_in)
                     | (!write && in_res && empty_out)
                     | (write && (a_in == 32'(CTRL_ADDR)) && !OP_VALID_MASK[op]);

    // access-phase outputs decoded from the transfer latched at SETUP
    assign access  = (state == ST_ACCESS);
    assign ok      = access && !err_q;
    assign ready   = access;
    assign slv_err = access && err_q;
    assign en_ctrl = ok && write_q && (a_q == 32'(CTRL_ADDR));
    assign mask_wr = ok && write_q && (a_q == 32'(MASK_A));

    // one-hot operand register load pulse
    always_comb begin
        en_data = '0;
        for (int k = 0; k < NUM_OPERANDS; k++)
            en_data[k] = ok && write_q && (a_q == 32'(DATA_BASE + k));
    end

    // read data is driven only in a clean read access, zero otherwise
    always_comb begin
        rdata = '0;
        if (ok && !write_q)
            rdata = (a_q == 32'(RES_A))    ? APB_BUS_SIZE'(final_result) :
                    (a_q == 32'(STATUS_A)) ? APB_BUS_SIZE'(fifo_out_status) :
                    (a_q == 32'(MASK_A))   ? APB_BUS_SIZE'(irq_mask) : '0;
    end

    csr_wait_counter #(.WIDTH(CW)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_SETUP),
        .load_val (CW'(READ_WAIT - 1)),
        .dec      (state == ST_WAIT),
        .done     (wait_done)
    );

    // APB phase sequencing; sel dropping mid-transfer abandons it
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   next_state = (sel && !en) ? ST_SETUP : ST_IDLE;
            ST_SETUP:  next_state = !sel ? ST_IDLE : res_ok ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   next_state = !sel ? ST_IDLE : wait_done ? ST_ACCESS : ST_WAIT;
            ST_ACCESS: next_state = (sel && !en) ? ST_SETUP : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // latch the transfer and its error verdict during SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else if (state == ST_SETUP) begin
            addr_q  <= addr;
            write_q <= write;
            err_q   <= setup_err;
            start_q <= wdata[START_BIT];
        end
    end

    // FIFO pulses: pop right after a legal RES setup, push right after a started CTRL write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= 1'b0;
            w_en_in  <= 1'b0;
        end else begin
            r_en_out <= (state == ST_SETUP) && sel && res_ok;
            w_en_in  <= en_ctrl && start_q;
        end
    end

    // interrupt mask, sticky error flag and registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask   <= '0;
            err_sticky <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (mask_wr)
                irq_mask <= wdata[1:0];
            if (slv_err)
                err_sticky <= 1'b1;
            else if (mask_wr && wdata[IRQ_CLR_BIT])
                err_sticky <= 1'b0;
            irq <= (irq_mask[IRQ_RES_BIT] && !empty_out) || (irq_mask[IRQ_ERR_BIT] && err_sticky);
        end
    end

endmodule

// File: tb/tb_csr_control_multi.sv
// tb_csr_control_multi: directed and random APB transfers checked against a register-map model
module tb_csr_control_multi;

    localparam int N  = 2;
    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  addr = '0;
    logic        sel = 1'b0;
    logic        en = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic [24:0] final_result = '0;
    logic [24:0] fifo_out_status = '0;
    logic        full_in = 1'b0;
    logic        empty_out = 1'b1;
    logic        ready, slv_err, en_ctrl, r_en_out, w_en_in, irq;
    logic [31:0] rdata;
    logic [1:0]  en_data;
    logic [38:0] outs;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  vmask = 4'b0110;
    logic [1:0]  m_mask = '0;
    logic        m_sticky = 1'b0;

    assign outs = {ready, slv_err, rdata, en_ctrl, en_data, r_en_out, w_en_in};

    csr_control_multi #(.READ_WAIT(RW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr            (addr),
        .sel             (sel),
        .en              (en),
        .write           (write),
        .wdata           (wdata),
        .final_result    (final_result),
        .fifo_out_status (fifo_out_status),
        .full_in         (full_in),
        .empty_out       (empty_out),
        .ready           (ready),
        .slv_err         (slv_err),
        .rdata           (rdata),
        .en_ctrl         (en_ctrl),
        .en_data         (en_data),
        .r_en_out        (r_en_out),
        .w_en_in         (w_en_in),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // one APB transfer; per-cycle activity is recorded as bit masks indexed from the setup cycle
    task automatic xfer(input logic w, input int a, input logic [31:0] d);
        logic [7:0]  rm, em, pm, cm, d0m, d1m, wm;
        logic [31:0] rd, exp_rd;
        logic        err, res_ok, opr, isres;
        int          lat;
        rm = '0; em = '0; pm = '0; cm = '0; d0m = '0; d1m = '0; wm = '0; rd = '0;
        opr    = (a <= N);
        isres  = (a == N + 1);
        err    = (a > N + 3) | (!w & opr) | (w & (isres | (a == N + 2))) | (w & opr & full_in)
               | (!w & isres & empty_out) | (w & (a == 0) & !vmask[d[1:0]]);
        res_ok = !err & !w & isres;
        lat    = res_ok ? 1 + RW : 1;
        exp_rd = '0;
        if (!err && !w)
            exp_rd = isres ? {7'b0, final_result} : (a == N + 2) ? {7'b0, fifo_out_status} : {30'b0, m_mask};
        @(negedge clk);
        sel = 1'b1; en = 1'b0; write = w; addr = 3'(a); wdata = d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rm[i] = ready; em[i] = slv_err; pm[i] = r_en_out; cm[i] = en_ctrl;
            d0m[i] = en_data[0]; d1m[i] = en_data[1]; wm[i] = w_en_in;
            if (ready) begin
                rd = rdata; sel = 1'b0; en = 1'b0;
            end else if (sel)
                en = 1'b1;
        end
        sel = 1'b0; en = 1'b0;
        chk("ready", 64'(rm), 64'(8'(1 << lat)));
        chk("slv_err", 64'(em), err ? 64'(8'(1 << lat)) : 64'h0);
        chk("r_en_out", 64'(pm), res_ok ? 64'h2 : 64'h0);
        chk("en_ctrl", 64'(cm), (!err && w && a == 0) ? 64'(8'(1 << lat)) : 64'h0);
        chk("en_data0", 64'(d0m), (!err && w && a == 1) ? 64'(8'(1 << lat)) : 64'h0);
        chk("en_data1", 64'(d1m), (!err && w && a == 2) ? 64'(8'(1 << lat)) : 64'h0);
        chk("w_en_in", 64'(wm), (!err && w && a == 0 && d[2]) ? 64'(8'(1 << (lat + 1))) : 64'h0);
        chk("rdata", 64'(rd), 64'(exp_rd));
        if (err)
            m_sticky = 1'b1;
        else if (w && a == N + 3) begin
            m_mask = d[1:0];
            if (d[2]) m_sticky = 1'b0;
        end
        chk("irq", 64'(irq), 64'((m_mask[0] & !empty_out) | (m_mask[1] & m_sticky)));
    endtask

    // start a legal RES read and stop in the first WAIT cycle
    task automatic res_read_to_wait();
        @(negedge clk);
        sel = 1'b1; en = 1'b0; write = 1'b0; addr = 3'(N + 1);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("wait_pop", 64'(r_en_out), 64'h1);
    endtask

    initial begin
        logic [7:0] rdy_seen;
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'(outs), 64'h0);
        chk("reset_irq", 64'(irq), 64'h0);
        rst_n = 1'b1;
        // enable without a setup cycle must be ignored
        sel = 1'b1; en = 1'b1; rdy_seen = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy_seen[i] = ready;
        end
        sel = 1'b0; en = 1'b0;
        chk("no_setup", 64'(rdy_seen), 64'h0);
        full_in = 1'b0; empty_out = 1'b0; final_result = 25'h0ABCDEF; fifo_out_status = 25'h1555AAA;
        xfer(1'b1, 2, 32'h1234);
        xfer(1'b1, 0, 32'h5);
        xfer(1'b0, N + 1, 32'h0);
        xfer(1'b1, 0, 32'h7);
        xfer(1'b0, N + 2, 32'h0);
        empty_out = 1'b1;
        xfer(1'b0, N + 1, 32'h0);
        empty_out = 1'b0;
        xfer(1'b1, 7, 32'h0);
        full_in = 1'b1;
        xfer(1'b1, 1, 32'h9);
        full_in = 1'b0;
        xfer(1'b0, 0, 32'h0);
        xfer(1'b1, N + 2, 32'h0);
        xfer(1'b1, N + 3, 32'h3);
        xfer(1'b1, 7, 32'h0);
        xfer(1'b0, N + 3, 32'h0);
        xfer(1'b1, N + 3, 32'h7);
        empty_out = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_empty", 64'(irq), 64'h0);
        for (int t = 0; t < 60; t++) begin
            full_in = ($urandom_range(0, 3) == 0);
            empty_out = ($urandom_range(0, 2) == 0);
            final_result = 25'($urandom);
            fifo_out_status = 25'($urandom);
            xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
        end
        // sel dropped in WAIT: transfer abandoned, bus returns to idle
        full_in = 1'b0; empty_out = 1'b0;
        res_read_to_wait();
        sel = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("drop_idle0", 64'(outs), 64'h0);
        @(negedge clk);
        chk("drop_idle1", 64'(outs), 64'h0);
        xfer(1'b0, N + 2, 32'h0);
        // asynchronous reset in WAIT
        res_read_to_wait();
        rst_n = 1'b0;
        #1;
        chk("rst_wait", 64'({outs, irq}), 64'h0);
        @(negedge clk);
        sel = 1'b0; en = 1'b0; rst_n = 1'b1;
        m_mask = '0; m_sticky = 1'b0;
        xfer(1'b0, N + 3, 32'h0);
        xfer(1'b1, 1, 32'hBEEF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_control_multi.md
Name: csr_control_multi

Overview:
- Parametrised successor to the ALU CSR control unit: an APB slave front-end for the ALU control/status register file, generalised to NUM_OPERANDS operand registers, a configurable read wait-state count for FIFO_OUT reads, and a per-opcode legality mask.
- Sits between the APB master and the CS registers / FIFO_IN / FIFO_OUT.
- Adds a proper APB phase FSM, a read/write IRQ_MASK register, a sticky error flag and a level interrupt output.

Parameters:
- NUM_OPERANDS, 2, number of operand registers DATA0..DATA(N-1).
- OPERATION_SIZE, 2, width of the opcode field in CTRL.
- OP_VALID_MASK, 4'b0110, bit i set means opcode i is legal (width 2**OPERATION_SIZE).
- FIFO_OUT_WIDTH, 25, width of final_result and fifo_out_status.
- APB_BUS_SIZE, 32, wdata/rdata width.
- READ_WAIT, 1, wait cycles for a RES read (≥1; covers FIFO_OUT read latency).
- ADDR_WIDTH, $clog2(NUM_OPERANDS+4), address width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  ADDR_WIDTH  APB address
- sel  in  1  APB select
- en  in  1  APB enable
- write  in  1  APB direction, 1 = write
- wdata  in  APB_BUS_SIZE  APB write data
- final_result  in  FIFO_OUT_WIDTH  FIFO_OUT head data
- fifo_out_status  in  FIFO_OUT_WIDTH  status word
- full_in  in  1  FIFO_IN full
- empty_out  in  1  FIFO_OUT empty
- ready  out  1  APB ready
- slv_err  out  1  APB error
- rdata  out  APB_BUS_SIZE  APB read data
- en_ctrl  out  1  CTRL register load pulse
- en_data  out  NUM_OPERANDS  one-hot operand register load pulse
- r_en_out  out  1  FIFO_OUT pop pulse
- w_en_in  out  1  FIFO_IN push pulse
- irq  out  1  interrupt, level

Behaviour:
- Register map:
  - CTRL = 0 (WO): bits [OPERATION_SIZE-1:0] = op, bit [OPERATION_SIZE] = start.
  - DATAk = 1+k (WO).
  - RES = N+1 (RO).
  - STATUS = N+2 (RO).
  - IRQ_MASK = N+3 (RW): bit0 = result irq enable, bit1 = error irq enable; writing bit2 = 1 clears err_sticky.
- Reset: all outputs 0, FSM in IDLE, IRQ_MASK = 0, err_sticky = 0.
- FSM states IDLE, SETUP, WAIT, ACCESS:
  - IDLE -> SETUP on sel & !en.
  - In SETUP, decode addr and latch the error condition.
  - SETUP -> ACCESS on the next cycle, unless this is a legal RES read; then SETUP -> WAIT.
  - WAIT counts READ_WAIT cycles, then -> ACCESS.
  - ACCESS: ready = 1 for exactly one cycle. Next state is SETUP if sel & !en, otherwise IDLE.
- Latency from the setup cycle T:
  - Writes, STATUS/IRQ_MASK reads and any errored transfer: ready at T+1.
  - Legal RES read: r_en_out pulses at T+1; ready at T+1+READ_WAIT.
- Error conditions (any one sets slv_err):
  - addr > N+3.
  - Read of CTRL/DATA.
  - Write of RES/STATUS.
  - Write of CTRL/DATA while full_in.
  - RES read while empty_out (sampled at SETUP).
  - CTRL write with OP_VALID_MASK[op] = 0.
- Error handling:
  - slv_err is high only in the ready cycle.
  - An errored transfer produces no side effects: no en_*, r_en_out or w_en_in, and no IRQ_MASK update.
  - slv_err sets err_sticky.
- Write side effects, in the ACCESS cycle:
  - en_ctrl, or en_data[k], pulses for one cycle.
  - IRQ_MASK is updated.
  - w_en_in pulses in the cycle after ACCESS for a legal CTRL write with start = 1.
- rdata:
  - Valid only when ready & !write & !slv_err: final_result, fifo_out_status or IRQ_MASK, zero-extended.
  - 0 otherwise.
- irq = (mask[0] & !empty_out) | (mask[1] & err_sticky), registered.
- sel dropped in SETUP or WAIT: return to IDLE with no ready and no side effects. If r_en_out has already fired, the popped data is lost; this is a documented protocol violation.
- en high without a preceding setup cycle: ignored, stay IDLE.
- Asynchronous reset mid-transfer: immediate IDLE, all outputs 0.

Decomposition:
- Shared package/include csr_pkg holds:
  - FSM state encodings.
  - Register offset functions of NUM_OPERANDS (CTRL, DATA base, RES, STATUS, IRQ_MASK).
  - CTRL field positions.
  - IRQ_MASK bit positions.
- One sub-module, csr_wait_counter: a loadable down-counter with a done flag, used for the WAIT state.

Test Plan:
- Write DATA1 = 0x1234 (N = 2) -> ready at T+1; en_data = 2'b10 for one cycle; slv_err = 0.
- Write CTRL op = 2'b01, start = 1, full_in = 0 -> en_ctrl pulses at T+1; w_en_in pulses at T+2.
- Read RES with READ_WAIT = 2, empty_out = 0, final_result = 0x0ABCDEF -> r_en_out at T+1; ready and rdata = 0x0ABCDEF at T+3.
- Error cases:
  - Write CTRL op = 2'b11 -> ready and slv_err at T+1, no en_ctrl.
  - Read RES with empty_out = 1 -> ready and slv_err at T+1, no r_en_out.
  - addr = 7 -> slv_err.
- Write IRQ_MASK = 0x3, then provoke an error -> irq = 1. Write IRQ_MASK = 0x7 -> err_sticky cleared; irq follows !empty_out.
- Drop sel during WAIT, and separately assert rst_n = 0 in WAIT -> FSM in IDLE, no ready, all outputs 0; the next transfer completes normally.
